// File: rtl/frac_prod_normalizer.sv
// Normalizer for the fractional product of a sequential multiplier.
// It captures the 13-bit product on a rising edge of done. It then shifts left until the MSB
// is set, one bit per cycle, and registers a 7-bit mantissa. The result is held until the
// downstream side accepts it.
// Optional feature: define ROUND_NEAREST_EN for round-to-nearest-even; default is truncation.
module frac_prod_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        done,
  input  logic [12:0] product,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [6:0]  mant,
  output logic [3:0]  shift_cnt,
  output logic        zero,
  output logic        busy,
  output logic        ovr
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StRound,
    StHold
  } state_e;

  state_e      state_q, state_d;
  logic        done_q;
  logic [12:0] work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [6:0]  mant_q, mant_d;
  logic [3:0]  shift_q, shift_d;
  logic        zero_q, zero_d;
  logic        ovr_q, ovr_d;

  logic        capture;
  logic        work_zero;
  logic        work_norm;
  logic [6:0]  trunc_m;
  logic [6:0]  rounded_m;

  // A capture is the first cycle done is seen high after being low.
  assign capture   = done & ~done_q;
  assign work_zero = (work_q == 13'd0);
  assign work_norm = work_q[12];
  assign trunc_m   = work_q[12:6];

`ifdef ROUND_NEAREST_EN
  logic guard;
  logic sticky;

  assign guard  = work_q[5];
  assign sticky = |work_q[4:0];

  // Round to nearest even; an all-ones mantissa saturates instead of wrapping.
  always_comb begin
    rounded_m = trunc_m;
    if (guard && (sticky || trunc_m[0]) && (trunc_m != 7'h7F)) begin
      rounded_m = trunc_m + 7'd1;
    end
  end
`else
  logic unused_work_lsbs;

  // Truncation: the bits below the mantissa do not contribute.
  assign unused_work_lsbs = ^work_q[5:0];
  assign rounded_m        = trunc_m;
`endif

  // Next-state and datapath decisions for the normalize sequence.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    mant_d  = mant_q;
    shift_d = shift_q;
    zero_d  = zero_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      StIdle: begin
        if (capture) begin
          work_d  = product;
          cnt_d   = 4'd0;
          state_d = StShift;
        end
      end

      StShift: begin
        if (capture) begin
          ovr_d = 1'b1;
        end
        if (work_norm || work_zero) begin
          state_d = StRound;
        end else begin
          work_d = {work_q[11:0], 1'b0};
          cnt_d  = cnt_q + 4'd1;
        end
      end

      StRound: begin
        if (capture) begin
          ovr_d = 1'b1;
        end
        mant_d  = work_zero ? 7'd0 : rounded_m;
        shift_d = cnt_q;
        zero_d  = work_zero;
        valid_d = 1'b1;
        state_d = StHold;
      end

      StHold: begin
        // A capture here is dropped even on the cycle the result is accepted.
        if (capture) begin
          ovr_d = 1'b1;
        end
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      // Preset high so a done already asserted at reset release is not a capture.
      done_q  <= 1'b1;
      work_q  <= 13'd0;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      mant_q  <= 7'd0;
      shift_q <= 4'd0;
      zero_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      mant_q  <= mant_d;
      shift_q <= shift_d;
      zero_q  <= zero_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid = valid_q;
  assign mant      = mant_q;
  assign shift_cnt = shift_q;
  assign zero      = zero_q;
  assign ovr       = ovr_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_frac_prod_normalizer.sv
// Testbench for frac_prod_normalizer: directed vectors, an arithmetic reference model,
// a per-cycle comparator and literal expectations for the worked examples.
module tb_frac_prod_normalizer;

  logic        clk;
  logic        rst_n;
  logic        done;
  logic [12:0] product;
  logic        out_ready;
  logic        out_valid;
  logic [6:0]  mant;
  logic [3:0]  shift_cnt;
  logic        zero;
  logic        busy;
  logic        ovr;

  int checks = 0;
  int errors = 0;

  frac_prod_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .done      (done),
    .product   (product),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .mant      (mant),
    .shift_cnt (shift_cnt),
    .zero      (zero),
    .busy      (busy),
    .ovr       (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic       m_prev;
  logic       m_cap;
  logic       m_busy;
  logic       m_valid;
  logic [6:0] m_mant;
  logic [3:0] m_shift;
  logic       m_zero;
  logic       m_ovr;
  int         m_left;
  logic [6:0] r_mant;
  logic [3:0] r_shift;
  logic       r_zero;
  int         r_lat;

  // Expected result of one product, computed arithmetically.
  task automatic model_result(input logic [12:0] p);
    int msb;
    int lz;
    int n;
    int q;
    int rem;
    msb = -1;
    for (int i = 0; i < 13; i++) begin
      if (p[i]) msb = i;
    end
    if (msb < 0) begin
      r_zero  = 1'b1;
      r_mant  = 7'd0;
      r_shift = 4'd0;
      r_lat   = 2;
    end else begin
      lz  = 12 - msb;
      n   = int'(p) * (1 << lz);
      q   = n / 64;
      rem = n % 64;
`ifdef ROUND_NEAREST_EN
      if (rem > 32 || (rem == 32 && (q % 2) == 1)) q = (q == 127) ? 127 : q + 1;
`endif
      r_zero  = 1'b0;
      r_mant  = 7'(q);
      r_shift = 4'(lz);
      r_lat   = lz + 2;
    end
  endtask

  // Model: a capture starts a countdown of the expected latency; the result then holds
  // until accepted. Any capture while not idle only sets the overrun flag.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_prev  = 1'b1;
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_mant  = 7'd0;
      m_shift = 4'd0;
      m_zero  = 1'b0;
      m_ovr   = 1'b0;
      m_left  = 0;
    end else begin
      m_cap  = done && !m_prev;
      m_prev = done;
      if (m_valid) begin
        if (m_cap) m_ovr = 1'b1;
        if (out_ready) begin
          m_valid = 1'b0;
          m_busy  = 1'b0;
        end
      end else if (m_busy) begin
        if (m_cap) m_ovr = 1'b1;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_valid = 1'b1;
          m_mant  = r_mant;
          m_shift = r_shift;
          m_zero  = r_zero;
        end
      end else if (m_cap) begin
        model_result(product);
        m_left = r_lat;
        m_busy = 1'b1;
      end
    end
  end

  // Compare every output against the model shortly after each active edge.
  always @(posedge clk) begin
    #1;
    checks++;
    if ({out_valid, busy, ovr, mant, shift_cnt, zero} !==
        {m_valid, m_busy, m_ovr, m_mant, m_shift, m_zero}) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got v=%b b=%b o=%b m=%h s=%0d z=%b want v=%b b=%b o=%b m=%h s=%0d z=%b",
               $time, out_valid, busy, ovr, mant, shift_cnt, zero,
               m_valid, m_busy, m_ovr, m_mant, m_shift, m_zero);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Raise done for one capture and count edges after the capture edge until out_valid.
  task automatic run_capture(input logic [12:0] p, output int lat);
    @(negedge clk);
    product = p;
    done    = 1'b1;
    lat     = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) done = 1'b0;
      if (out_valid) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n     = 1'b0;
    done      = 1'b0;
    product   = 13'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);

    // Six leading zeros.
    run_capture(13'h0040, lat);
    chk("p0040_lat", lat, 8);
    chk("p0040_mant", int'(mant), 'h40);
    chk("p0040_shift", int'(shift_cnt), 6);
    chk("p0040_zero", int'(zero), 0);
    accept();

    run_capture(13'h1560, lat);
    chk("p1560_lat", lat, 2);
    chk("p1560_shift", int'(shift_cnt), 0);
`ifdef ROUND_NEAREST_EN
    chk("p1560_mant", int'(mant), 'h56);
`else
    chk("p1560_mant", int'(mant), 'h55);
`endif
    accept();

    // Saturates under rounding, plain all-ones under truncation.
    run_capture(13'h1FE0, lat);
    chk("p1fe0_mant", int'(mant), 'h7F);
    chk("p1fe0_shift", int'(shift_cnt), 0);
    accept();

    // Tie with even mantissa stays put.
    run_capture(13'h1420, lat);
    chk("p1420_mant", int'(mant), 'h50);
    accept();

    run_capture(13'h0123, lat);
    chk("p0123_lat", lat, 6);
    chk("p0123_shift", int'(shift_cnt), 4);
`ifdef ROUND_NEAREST_EN
    chk("p0123_mant", int'(mant), 'h49);
`else
    chk("p0123_mant", int'(mant), 'h48);
`endif
    accept();

    // Zero product, then a dropped capture while holding.
    run_capture(13'h0000, lat);
    chk("zero_lat", lat, 2);
    chk("zero_flag", int'(zero), 1);
    chk("zero_mant", int'(mant), 0);
    chk("zero_shift", int'(shift_cnt), 0);
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_ovr", int'(ovr), 1);
    chk("hold_valid", int'(out_valid), 1);
    chk("hold_zero", int'(zero), 1);
    chk("hold_mant", int'(mant), 0);
    accept();

    // Reset in the middle of shifting, with done held high through release.
    @(negedge clk);
    product = 13'h0001;
    done    = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(ovr), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_mant", int'(mant), 0);
    chk("rst_shift", int'(shift_cnt), 0);
    chk("rst_zero", int'(zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("held_done_busy", int'(busy), 0);
    end
    @(negedge clk);
    done = 1'b0;

    // Deepest shift with the consumer always ready.
    @(negedge clk);
    out_ready = 1'b1;
    run_capture(13'h0001, lat);
    chk("p0001_lat", lat, 14);
    chk("p0001_shift", int'(shift_cnt), 12);
    chk("p0001_mant", int'(mant), 'h40);
    @(posedge clk);
    #1;
    chk("p0001_pulse", int'(out_valid), 0);
    @(negedge clk);
    out_ready = 1'b0;

    repeat (4) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
